roi_gray_binarize: RTL and testbench

ROI_GRAY_BINARIZE -- requirements
Module: roi_gray_binarize

---
 rtl/roi_gray_binarize.sv | 140 ++++++++++++++
 tb/tb_roi_gray_binarize.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_gray_binarize.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : roi_gray_binarize                                              |
// | Description : Two-stage AXI4-Stream RGB->gray->binary pixel pipeline with    |
// |               frame statistics (white pixel count, frame done, line error).  |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module roi_gray_binarize #(
    parameter int IMAGE_WIDTH      = 640,
    parameter int IMAGE_HEIGHT     = 480,
    parameter int AXIS_TDATA_WIDTH = 24,
    parameter int THRESHOLD        = 128
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        frame_done,
    output logic [18:0]                 white_count,
    output logic                        err_line
);

    localparam logic [9:0] c_COL_LAST = 10'(IMAGE_WIDTH - 1);
    localparam logic [8:0] c_ROW_LAST = 9'(IMAGE_HEIGHT - 1);
    localparam logic [7:0] c_THRESH   = 8'(THRESHOLD);

    logic                        w_adv;
    logic [15:0]                 w_gray_sum;
    logic                        r_s1_valid;
    logic [7:0]                  r_s1_gray;
    logic                        r_s1_last;
    logic                        r_s1_user;
    logic                        r_m_valid;
    logic [AXIS_TDATA_WIDTH-1:0] r_m_data;
    logic                        r_m_last;
    logic                        r_m_user;

    assign w_adv         = m_axis_tready | ~r_m_valid;
    assign s_axis_tready = w_adv;

    // Weights sum to 256, so the 16-bit sum never overflows.
    assign w_gray_sum = 16'd77  * {8'd0, s_axis_tdata[23:16]}
                      + 16'd150 * {8'd0, s_axis_tdata[15:8]}
                      + 16'd29  * {8'd0, s_axis_tdata[7:0]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1_valid <= 1'b0;
            r_s1_gray  <= 8'd0;
            r_s1_last  <= 1'b0;
            r_s1_user  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_m_user   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= s_axis_tvalid;
            r_s1_gray  <= 8'(w_gray_sum >> 8);
            r_s1_last  <= s_axis_tlast;
            r_s1_user  <= s_axis_tuser;
            r_m_valid  <= r_s1_valid;
            r_m_data   <= (r_s1_gray >= c_THRESH) ? {AXIS_TDATA_WIDTH{1'b1}} : '0;
            r_m_last   <= r_s1_last;
            r_m_user   <= r_s1_user;
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;

    logic        w_hs;
    logic [9:0]  w_col_eff;
    logic [8:0]  w_row_eff;
    logic [18:0] w_run_eff;
    logic [18:0] w_run_next;
    logic        w_len_err;
    logic [9:0]  r_col;
    logic [8:0]  r_row;
    logic [18:0] r_run;
    logic        r_frame_done;
    logic [18:0] r_white_count;
    logic        r_err_line;

    // Start-of-frame overrides position and count before this beat is evaluated.
    assign w_hs       = r_m_valid & m_axis_tready;
    assign w_col_eff  = r_m_user ? 10'd0 : r_col;
    assign w_row_eff  = r_m_user ? 9'd0  : r_row;
    assign w_run_eff  = r_m_user ? 19'd0 : r_run;
    assign w_run_next = w_run_eff + {18'd0, r_m_data[0]};
    assign w_len_err  = r_m_last ? (w_col_eff != c_COL_LAST) : (w_col_eff == c_COL_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_col         <= 10'd0;
            r_row         <= 9'd0;
            r_run         <= 19'd0;
            r_frame_done  <= 1'b0;
            r_white_count <= 19'd0;
            r_err_line    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_hs) begin
                if (w_len_err)
                    r_err_line <= 1'b1;
                if (r_m_last) begin
                    r_col <= 10'd0;
                    if (w_row_eff == c_ROW_LAST) begin
                        r_row         <= 9'd0;
                        r_run         <= 19'd0;
                        r_frame_done  <= 1'b1;
                        r_white_count <= w_run_next;
                    end else begin
                        r_row <= w_row_eff + 9'd1;
                        r_run <= w_run_next;
                    end
                end else begin
                    r_col <= w_col_eff + 10'd1;
                    r_row <= w_row_eff;
                    r_run <= w_run_next;
                end
            end
        end
    end

    assign frame_done  = r_frame_done;
    assign white_count = r_white_count;
    assign err_line    = r_err_line;

endmodule
`default_nettype wire

// File: tb/tb_roi_gray_binarize.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_roi_gray_binarize                                           |
// | Description : Self-checking bench for roi_gray_binarize on a reduced frame.  |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_roi_gray_binarize;

    localparam int W      = 16;
    localparam int H      = 6;
    localparam int TH     = 128;
    localparam int SHORTL = 11;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;
    logic [18:0] white_count;
    logic        err_line;

    roi_gray_binarize #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .AXIS_TDATA_WIDTH(24), .THRESHOLD(TH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .frame_done(frame_done), .white_count(white_count), .err_line(err_line)
    );

    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_done = 0;
    int          n_stalls = 0;
    bit          rand_ready = 1'b0;
    logic [25:0] exp_q[$];

    function automatic int gray(input logic [23:0] d);
        return (77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0])) / 256;
    endfunction

    function automatic logic [23:0] model_pix(input logic [23:0] d);
        return (gray(d) >= TH) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        #1;
        m_axis_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Output monitor: beat order against the expected queue, and hold during stalls.
    logic        prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;
    initial forever begin
        @(negedge aclk);
        if (areset) begin
            prev_stall = 1'b0;
            continue;
        end
        if (frame_done) n_done++;
        if (prev_stall) begin
            n_vec++;
            assert (m_axis_tvalid === 1'b1 && {m_axis_tdata, m_axis_tlast, m_axis_tuser} === prev_beat) else begin
                n_err++;
                $error("FAIL stall_hold: observed v=%b %h expected v=1 %h", m_axis_tvalid,
                       {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_beat);
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            logic [25:0] e;
            n_out++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL extra_beat: observed %h expected none", {m_axis_tdata, m_axis_tlast, m_axis_tuser});
            end else begin
                e = exp_q.pop_front();
                assert ({m_axis_tdata, m_axis_tlast, m_axis_tuser} === e) else begin
                    n_err++;
                    $error("FAIL out_beat: observed %h expected %h", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
                end
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end

    task automatic send(input logic [23:0] d, input logic last, input logic user);
        int   guard = 0;
        logic hs = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!hs) begin
            @(negedge aclk);
            hs = s_axis_tready;
            if (!hs) n_stalls++;
            @(posedge aclk);
            #1;
            if (++guard > 1000) begin
                n_err++;
                $display("FAIL send_timeout: observed no tready expected handshake");
                $fatal(1, "input handshake timed out");
            end
        end
        exp_q.push_back({model_pix(d), last, user});
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge aclk);
            #1;
            g++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    // mode 0: left half white, right half black; mode 1: random pixels
    task automatic send_frame(input int mode, input int short_row, output int whites);
        logic [23:0] d;
        int          len;
        whites = 0;
        n_out = 0;
        n_done = 0;
        n_stalls = 0;
        for (int r = 0; r < H; r++) begin
            len = (r == short_row) ? SHORTL : W;
            for (int c = 0; c < len; c++) begin
                d = (mode == 0) ? ((c < W / 2) ? 24'hFFFFFF : 24'h000000) : 24'($urandom);
                if (gray(d) >= TH) whites++;
                send(d, c == len - 1, r == 0 && c == 0);
            end
        end
        drain();
    endtask

    int wh;

    initial begin
        #2;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_wcount", white_count, 0);
        chk("rst_err", err_line, 0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_tready", s_axis_tready, 1);

        // Two-cycle latency on an empty pipeline
        send(24'hFF0000, 1'b0, 1'b1);
        chk("lat_cyc1_valid", m_axis_tvalid, 0);
        @(posedge aclk);
        #1;
        chk("lat_cyc2_valid", m_axis_tvalid, 1);
        chk("lat_cyc2_data", m_axis_tdata, 24'h000000);
        chk("lat_cyc2_user", m_axis_tuser, 1);
        drain();

        // Threshold neighbourhood: gray 127, 128, 129
        send(24'h7F7F7F, 1'b0, 1'b0);
        send(24'h808080, 1'b0, 1'b0);
        send(24'h818181, 1'b0, 1'b0);
        drain();
        chk("thr_err", err_line, 0);

        send_frame(0, -1, wh);
        chk("fA_outs", n_out, W * H);
        chk("fA_done", n_done, 1);
        chk("fA_white", white_count, W * H / 2);
        chk("fA_err", err_line, 0);
        chk("fA_throughput", n_stalls, 0);

        rand_ready = 1'b1;
        send_frame(0, -1, wh);
        chk("fB_outs", n_out, W * H);
        chk("fB_done", n_done, 1);
        chk("fB_white", white_count, W * H / 2);

        send_frame(1, -1, wh);
        chk("fC_outs", n_out, W * H);
        chk("fC_done", n_done, 1);
        chk("fC_white", white_count, wh);
        chk("fC_err", err_line, 0);

        // Short line in row 1: sticky error, rows keep counting
        send_frame(1, 1, wh);
        chk("fD_err", err_line, 1);
        chk("fD_done", n_done, 1);
        chk("fD_white", white_count, wh);
        chk("fD_outs", n_out, W * H - (W - SHORTL));
        send_frame(1, -1, wh);
        chk("fD2_err_sticky", err_line, 1);
        chk("fD2_white", white_count, wh);

        // Reset with beats in flight
        rand_ready = 1'b0;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 5; i++) send(24'($urandom), 1'b0, i == 0);
        #1;
        areset = 1'b1;
        exp_q.delete();
        #1;
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_tdata", m_axis_tdata, 0);
        chk("mrst_tuser", m_axis_tuser, 0);
        chk("mrst_done", frame_done, 0);
        chk("mrst_wcount", white_count, 0);
        chk("mrst_err", err_line, 0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("mrst_tready", s_axis_tready, 1);
        chk("mrst_tvalid2", m_axis_tvalid, 0);

        rand_ready = 1'b1;
        send_frame(1, -1, wh);
        chk("fE_outs", n_out, W * H);
        chk("fE_done", n_done, 1);
        chk("fE_white", white_count, wh);
        chk("fE_err", err_line, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
